// File: rtl/axi4l_param_slave_pkg.sv
// Shared AXI4-Lite response codes and elaboration helpers for the parametrised slave.
// Pure constants/types; no timing or backpressure of its own.
package axi4l_param_slave_pkg;

    typedef logic [1:0] resp_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_SLVERR = 2'b10;

    // Ceiling log2 for parameter arithmetic; clog2(1) is 0.
    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) res = i + 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/axi4l_param_slave_if.sv
// AXI4-Lite bus bundle between an interconnect master and the register slave.
// Plain wiring: latency and backpressure are set by whoever drives each side.
interface axi4l_param_slave_if
    import axi4l_param_slave_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
);

    logic                      awvalid;
    logic                      awready;
    logic [ADDR_WIDTH-1:0]     awaddr;
    logic                      wvalid;
    logic                      wready;
    logic [DATA_WIDTH-1:0]     wdata;
    logic [DATA_WIDTH/8-1:0]   wstrb;
    logic                      bvalid;
    logic                      bready;
    resp_t                     bresp;
    logic                      arvalid;
    logic                      arready;
    logic [ADDR_WIDTH-1:0]     araddr;
    logic                      rvalid;
    logic                      rready;
    logic [DATA_WIDTH-1:0]     rdata;
    resp_t                     rresp;

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

endinterface

// File: rtl/axi4l_param_slave_regfile.sv
// Word storage with one byte-enabled write port and one registered read port plus range flags.
// Write takes effect on the edge; read data/error register on rd_en_i and hold otherwise.
module axi4l_param_slave_regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 3,
    parameter int IDX_W      = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    wr_en_i,
    input  logic [IDX_W-1:0]        wr_idx_i,
    input  logic [DATA_WIDTH-1:0]   wr_data_i,
    input  logic [DATA_WIDTH/8-1:0] wr_strb_i,
    output logic                    wr_err_o,
    input  logic                    rd_en_i,
    input  logic [IDX_W-1:0]        rd_idx_i,
    output logic [DATA_WIDTH-1:0]   rd_data_o,
    output logic                    rd_err_o
);

    localparam int STRB_W = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_err_q, rd_err_d;

    // Decoding by compare loop keeps indices beyond NUM_REGS from ever touching storage.
    always_comb begin
        wr_err_o  = 1'b1;
        rd_err_d  = 1'b1;
        rd_data_d = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_idx_i == IDX_W'(i)) wr_err_o = 1'b0;
            if (rd_idx_i == IDX_W'(i)) begin
                rd_err_d  = 1'b0;
                rd_data_d = mem_q[i];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
            rd_data_q <= '0;
            rd_err_q  <= 1'b0;
        end else begin
            if (wr_en_i) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (wr_idx_i == IDX_W'(i)) begin
                        for (int b = 0; b < STRB_W; b++) begin
                            if (wr_strb_i[b]) mem_q[i][8*b +: 8] <= wr_data_i[8*b +: 8];
                        end
                    end
                end
            end
            if (rd_en_i) begin
                rd_data_q <= rd_data_d;
                rd_err_q  <= rd_err_d;
            end
        end
    end

    assign rd_data_o = rd_data_q;
    assign rd_err_o  = rd_err_q;

endmodule

// File: rtl/axi4l_param_slave.sv
// AXI4-Lite register bank: AW/W holders commit to regfile, B one cycle after commit, R one cycle after AR.
// B/R outputs hold until accepted; a full holder or an unaccepted response deasserts the matching READY.
module axi4l_param_slave
    import axi4l_param_slave_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_REGS   = 3
) (
    input  logic               i_ACLK,
    input  logic               i_ARESETN,
    axi4l_param_slave_if.slave s_axi
);

    localparam int ADDR_LSB = clog2(DATA_WIDTH / 8);
    localparam int IDX_W    = ADDR_WIDTH - ADDR_LSB;
    localparam int STRB_W   = DATA_WIDTH / 8;

    logic                  r_live_q;
    logic                  aw_full_q, aw_full_d;
    logic [IDX_W-1:0]      aw_idx_q,  aw_idx_d;
    logic                  w_full_q,  w_full_d;
    logic [DATA_WIDTH-1:0] w_data_q,  w_data_d;
    logic [STRB_W-1:0]     w_strb_q,  w_strb_d;
    logic                  b_vld_q,   b_vld_d;
    resp_t                 b_resp_q,  b_resp_d;
    logic                  r_vld_q,   r_vld_d;

    logic                  aw_hs, w_hs, ar_hs, commit;
    logic                  wr_err, rd_err;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  unused_addr_bits;

    // Sub-word address bits are ignored; referencing them here keeps them visibly accounted for.
    assign unused_addr_bits = ^{s_axi.awaddr, s_axi.araddr};

    assign s_axi.awready = r_live_q & ~aw_full_q;
    assign s_axi.wready  = r_live_q & ~w_full_q;
    assign s_axi.arready = r_live_q & (~r_vld_q | s_axi.rready);

    assign aw_hs  = s_axi.awvalid & s_axi.awready;
    assign w_hs   = s_axi.wvalid  & s_axi.wready;
    assign ar_hs  = s_axi.arvalid & s_axi.arready;
    assign commit = aw_full_q & w_full_q & (~b_vld_q | s_axi.bready);

    always_comb begin
        aw_full_d = aw_full_q;
        aw_idx_d  = aw_idx_q;
        w_full_d  = w_full_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        b_vld_d   = b_vld_q;
        b_resp_d  = b_resp_q;
        r_vld_d   = r_vld_q;

        if (aw_hs) begin
            aw_full_d = 1'b1;
            aw_idx_d  = s_axi.awaddr[ADDR_WIDTH-1:ADDR_LSB];
        end
        if (w_hs) begin
            w_full_d = 1'b1;
            w_data_d = s_axi.wdata;
            w_strb_d = s_axi.wstrb;
        end

        // A commit reloads B even while the previous response is being accepted.
        if (commit) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
            b_vld_d   = 1'b1;
            b_resp_d  = wr_err ? RESP_SLVERR : RESP_OKAY;
        end else if (s_axi.bready) begin
            b_vld_d = 1'b0;
        end

        if (ar_hs) begin
            r_vld_d = 1'b1;
        end else if (s_axi.rready) begin
            r_vld_d = 1'b0;
        end
    end

    always_ff @(posedge i_ACLK or negedge i_ARESETN) begin
        if (!i_ARESETN) begin
            r_live_q  <= 1'b0;
            aw_full_q <= 1'b0;
            aw_idx_q  <= '0;
            w_full_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            b_vld_q   <= 1'b0;
            b_resp_q  <= RESP_OKAY;
            r_vld_q   <= 1'b0;
        end else begin
            r_live_q  <= 1'b1;
            aw_full_q <= aw_full_d;
            aw_idx_q  <= aw_idx_d;
            w_full_q  <= w_full_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            b_vld_q   <= b_vld_d;
            b_resp_q  <= b_resp_d;
            r_vld_q   <= r_vld_d;
        end
    end

    // Read samples storage before a same-cycle commit lands, so it returns the old word.
    axi4l_param_slave_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .IDX_W      (IDX_W)
    ) u_regfile (
        .clk_i     (i_ACLK),
        .rst_ni    (i_ARESETN),
        .wr_en_i   (commit),
        .wr_idx_i  (aw_idx_q),
        .wr_data_i (w_data_q),
        .wr_strb_i (w_strb_q),
        .wr_err_o  (wr_err),
        .rd_en_i   (ar_hs),
        .rd_idx_i  (s_axi.araddr[ADDR_WIDTH-1:ADDR_LSB]),
        .rd_data_o (rd_data),
        .rd_err_o  (rd_err)
    );

    assign s_axi.bvalid = b_vld_q;
    assign s_axi.bresp  = b_resp_q;
    assign s_axi.rvalid = r_vld_q;
    assign s_axi.rdata  = rd_data;
    assign s_axi.rresp  = rd_err ? RESP_SLVERR : RESP_OKAY;

endmodule

// File: tb/tb_axi4l_param_slave.sv
// Scoreboarded bench for axi4l_param_slave: directed corner cases then randomized traffic vs a word-array model.
module tb_axi4l_param_slave;
    import axi4l_param_slave_pkg::*;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int NR = 3;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } rexp_t;

    logic clk = 1'b0;
    logic arstn = 1'b0;
    always #5 clk = ~clk;

    axi4l_param_slave_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    axi4l_param_slave #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .NUM_REGS   (NR)
    ) dut (
        .i_ACLK    (clk),
        .i_ARESETN (arstn),
        .s_axi     (bus)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mdl [NR];
    logic [1:0]  b_q [$];
    rexp_t       r_q [$];
    logic [1:0]  b_exp;
    rexp_t       r_exp;
    rexp_t       t_exp;
    logic        b_rand = 1'b0, r_rand = 1'b0;
    logic        b_force = 1'b1, r_force = 1'b1;
    logic [3:0]  rnd_a;
    logic [31:0] rnd_d;
    logic [3:0]  rnd_s;
    int          rnd_n;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out, expected a handshake/response", name);
    endtask

    // Reference model: byte address / 4 selects a word; words past NR are an error.
    function automatic logic [1:0] mdl_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        int idx;
        idx = int'(a) / 4;
        if (idx >= NR) return RESP_SLVERR;
        for (int b = 0; b < 4; b++) if (s[b]) mdl[idx][8*b +: 8] = d[8*b +: 8];
        return RESP_OKAY;
    endfunction

    function automatic rexp_t exp_read(input logic [3:0] a);
        rexp_t r;
        int idx;
        idx = int'(a) / 4;
        if (idx >= NR) begin
            r.data = 32'h0;
            r.resp = RESP_SLVERR;
        end else begin
            r.data = mdl[idx];
            r.resp = RESP_OKAY;
        end
        return r;
    endfunction

    // Sole driver of the response-ready lines.
    initial begin
        bus.bready = 1'b0;
        bus.rready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            bus.bready = b_rand ? ($urandom_range(0, 3) != 0) : b_force;
            bus.rready = r_rand ? ($urandom_range(0, 3) != 0) : r_force;
        end
    end

    // Monitor: pop and compare on every accepted response.
    always @(negedge clk) begin
        if (arstn && bus.bvalid && bus.bready) begin
            if (b_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL b_unexpected: got bresp 0x%0h, expected no response", bus.bresp);
            end else begin
                b_exp = b_q.pop_front();
                chk("bresp", 64'(bus.bresp), 64'(b_exp));
            end
        end
        if (arstn && bus.rvalid && bus.rready) begin
            if (r_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL r_unexpected: got rdata 0x%0h, expected no response", bus.rdata);
            end else begin
                r_exp = r_q.pop_front();
                chk("rdata", 64'(bus.rdata), 64'(r_exp.data));
                chk("rresp", 64'(bus.rresp), 64'(r_exp.resp));
            end
        end
    end

    task automatic send_aw(input logic [3:0] a);
        bit hs;
        hs = 1'b0;
        bus.awaddr = a; bus.awvalid = 1'b1;
        for (int n = 0; n < 50 && !hs; n++) begin
            @(negedge clk); hs = bus.awready;
            @(posedge clk); #1;
        end
        bus.awvalid = 1'b0;
        if (!hs) timeout("aw_handshake");
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s);
        bit hs;
        hs = 1'b0;
        bus.wdata = d; bus.wstrb = s; bus.wvalid = 1'b1;
        for (int n = 0; n < 50 && !hs; n++) begin
            @(negedge clk); hs = bus.wready;
            @(posedge clk); #1;
        end
        bus.wvalid = 1'b0;
        if (!hs) timeout("w_handshake");
    endtask

    task automatic send_ar(input logic [3:0] a, input bit drop);
        bit hs;
        hs = 1'b0;
        bus.araddr = a; bus.arvalid = 1'b1;
        for (int n = 0; n < 50 && !hs; n++) begin
            @(negedge clk); hs = bus.arready;
            if (hs) r_q.push_back(exp_read(a));
            @(posedge clk); #1;
        end
        if (drop) bus.arvalid = 1'b0;
        if (!hs) timeout("ar_handshake");
    endtask

    task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int order, input int gap);
        b_q.push_back(mdl_write(a, d, s));
        if (order == 0) begin
            fork
                send_aw(a);
                send_w(d, s);
            join
        end else if (order == 1) begin
            send_aw(a);
            repeat (gap) begin @(posedge clk); #1; end
            send_w(d, s);
        end else begin
            send_w(d, s);
            repeat (gap) begin @(posedge clk); #1; end
            send_aw(a);
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((b_q.size() != 0 || r_q.size() != 0) && n < 300) begin
            @(posedge clk); #1; n++;
        end
        if (b_q.size() != 0 || r_q.size() != 0) begin
            timeout("drain");
            b_q.delete();
            r_q.delete();
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_awready"}, 64'(bus.awready), 64'h0);
        chk({tag, "_wready"},  64'(bus.wready),  64'h0);
        chk({tag, "_arready"}, 64'(bus.arready), 64'h0);
        chk({tag, "_bvalid"},  64'(bus.bvalid),  64'h0);
        chk({tag, "_bresp"},   64'(bus.bresp),   64'h0);
        chk({tag, "_rvalid"},  64'(bus.rvalid),  64'h0);
        chk({tag, "_rdata"},   64'(bus.rdata),   64'h0);
        chk({tag, "_rresp"},   64'(bus.rresp),   64'h0);
    endtask

    task automatic chk_readys(input string tag, input logic v);
        chk({tag, "_awready"}, 64'(bus.awready), 64'(v));
        chk({tag, "_wready"},  64'(bus.wready),  64'(v));
        chk({tag, "_arready"}, 64'(bus.arready), 64'(v));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < NR; i++) mdl[i] = 32'h0;
        bus.awvalid = 1'b0; bus.awaddr = '0;
        bus.wvalid = 1'b0;  bus.wdata = '0; bus.wstrb = '0;
        bus.arvalid = 1'b0; bus.araddr = '0;

        // Reset and single-cycle READY hold-off
        arstn = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk_idle("rst");
        arstn = 1'b1;
        @(negedge clk); chk_readys("rel_cycle0", 1'b0);
        @(posedge clk); #1;
        @(negedge clk); chk_readys("rel_cycle1", 1'b1);
        @(posedge clk); #1;

        // 1: AW+W same cycle, B two cycles after handshake, read back
        b_q.push_back(mdl_write(4'h4, 32'hDEADBEEF, 4'hF));
        fork
            send_aw(4'h4);
            send_w(32'hDEADBEEF, 4'hF);
        join
        @(negedge clk); chk("t1_bvalid_early", 64'(bus.bvalid), 64'h0);
        @(negedge clk); chk("t1_bvalid", 64'(bus.bvalid), 64'h1);
        @(posedge clk); #1;
        wait_drain();
        send_ar(4'h4, 1'b1);
        @(negedge clk);
        chk("t1_rvalid", 64'(bus.rvalid), 64'h1);
        chk("t1_rdata", 64'(bus.rdata), 64'hDEADBEEF);
        @(posedge clk); #1;
        wait_drain();

        // 2: W leads AW by 3 cycles; no commit until AW arrives
        b_q.push_back(mdl_write(4'h5, 32'h11223344, 4'b0101));
        send_w(32'h11223344, 4'b0101);
        repeat (3) begin
            @(negedge clk);
            chk("t2_no_commit", 64'(bus.bvalid), 64'h0);
            chk("t2_wready_held", 64'(bus.wready), 64'h0);
            @(posedge clk); #1;
        end
        send_aw(4'h5);
        wait_drain();
        send_ar(4'h4, 1'b1);
        @(negedge clk); chk("t2_rdata", 64'(bus.rdata), 64'hDE22BE44);
        @(posedge clk); #1;
        wait_drain();

        // 3: out-of-range write and read
        do_write(4'hC, 32'hCAFEF00D, 4'hF, 0, 0);
        wait_drain();
        send_ar(4'hC, 1'b0);
        send_ar(4'h0, 1'b0);
        send_ar(4'h4, 1'b0);
        send_ar(4'h8, 1'b1);
        wait_drain();

        // 4: B backpressure with a second write parked in the holders
        b_force = 1'b0;
        @(posedge clk); #1;
        do_write(4'h0, 32'hA5A5A5A5, 4'hF, 0, 0);
        do_write(4'hD, 32'h01020304, 4'hF, 0, 0);
        repeat (5) begin
            @(negedge clk);
            chk("t4_bvalid_hold", 64'(bus.bvalid), 64'h1);
            chk("t4_bresp_hold", 64'(bus.bresp), 64'h0);
            chk("t4_awready", 64'(bus.awready), 64'h0);
            chk("t4_wready", 64'(bus.wready), 64'h0);
            @(posedge clk); #1;
        end
        b_force = 1'b1;
        @(posedge clk); #1;
        b_force = 1'b0;
        @(negedge clk);
        chk("t4_second_bvalid", 64'(bus.bvalid), 64'h1);
        chk("t4_second_bresp", 64'(bus.bresp), 64'h2);
        b_force = 1'b1;
        wait_drain();

        // 5: R backpressure then streaming reads
        r_force = 1'b0;
        @(posedge clk); #1;
        bus.araddr = 4'h0; bus.arvalid = 1'b1;
        @(negedge clk);
        chk("t5_arready_first", 64'(bus.arready), 64'h1);
        if (bus.arready) r_q.push_back(exp_read(4'h0));
        @(posedge clk); #1;
        bus.araddr = 4'h4;
        t_exp = exp_read(4'h0);
        repeat (3) begin
            @(negedge clk);
            chk("t5_arready_stall", 64'(bus.arready), 64'h0);
            chk("t5_rvalid_hold", 64'(bus.rvalid), 64'h1);
            chk("t5_rdata_hold", 64'(bus.rdata), 64'(t_exp.data));
            @(posedge clk); #1;
        end
        r_force = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t5_stream_arready", 64'(bus.arready), 64'h1);
            chk("t5_stream_rvalid", 64'(bus.rvalid), 64'h1);
            if (bus.arready) r_q.push_back(exp_read(bus.araddr));
            @(posedge clk); #1;
            bus.araddr = bus.araddr + 4'h4;
        end
        bus.arvalid = 1'b0;
        wait_drain();

        // Randomized traffic with random B/R backpressure
        b_rand = 1'b1; r_rand = 1'b1;
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 1) == 1) begin
                rnd_a = 4'($urandom_range(0, 15));
                rnd_d = $urandom;
                rnd_s = 4'($urandom_range(0, 15));
                do_write(rnd_a, rnd_d, rnd_s, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
                wait_drain();
            end else begin
                rnd_n = int'($urandom_range(1, 4));
                for (int k = 0; k < rnd_n; k++) begin
                    rnd_a = 4'($urandom_range(0, 15));
                    send_ar(rnd_a, k == rnd_n - 1);
                end
                wait_drain();
            end
        end
        b_rand = 1'b0; r_rand = 1'b0;
        @(posedge clk); #1;

        // 6: reset while only AW is parked
        send_aw(4'h0);
        arstn = 1'b0;
        #1 chk_idle("t6_rst");
        for (int i = 0; i < NR; i++) mdl[i] = 32'h0;
        b_q.delete();
        r_q.delete();
        repeat (2) @(posedge clk);
        #1 arstn = 1'b1;
        @(negedge clk); chk_readys("t6_rel_cycle0", 1'b0);
        @(posedge clk); #1;
        @(negedge clk); chk_readys("t6_rel_cycle1", 1'b1);
        @(posedge clk); #1;
        send_w(32'h0BADF00D, 4'hF);
        repeat (3) begin
            @(negedge clk);
            chk("t6_aw_dropped", 64'(bus.bvalid), 64'h0);
            @(posedge clk); #1;
        end
        b_q.push_back(mdl_write(4'h8, 32'h0BADF00D, 4'hF));
        send_aw(4'h8);
        wait_drain();
        send_ar(4'h0, 1'b0);
        send_ar(4'h4, 1'b0);
        send_ar(4'h8, 1'b1);
        wait_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
